// File: rtl/intellitec_bus_master_if.sv
// IntellitecSignal 4-wire bus: the master drives mt12/mt2, the slaves answer on tm2/tm4.
interface IntellitecSignal;
   logic mt12;
   logic mt2;
   logic tm2;
   logic tm4;

   modport master (output mt12, output mt2, input tm2, input tm4);
   modport slave  (input mt12, input mt2, output tm2, output tm4);
endinterface

// File: rtl/intellitec_bus_master.sv
// Intellitec bus master: frames NUM_ZONES thermostat zones, sends load-shed bits, commits slave replies per frame.
// Optional macro PROTOCOL_CHECK_EN rejects frames carrying the illegal fan code (tm2=tm4=1 in a zone's fan slot).
module intellitec_bus_master #(
   parameter int NUM_ZONES      = 2,
   parameter int SLOTS_PER_ZONE = 4,
   parameter int PAD_SLOTS      = 2,
   parameter int SYNC_TICKS     = 3,
   parameter int BIT_TICKS      = 8,
   parameter int SAMPLE_TICK    = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_ZONES-1:0] shed,
   IntellitecSignal.master      it,
   output logic [NUM_ZONES-1:0] ac_n,
   output logic [NUM_ZONES-1:0] fan_on_n,
   output logic [NUM_ZONES-1:0] fan_high_n,
   output logic [NUM_ZONES-1:0] heat_n,
   output logic                 frame_done,
   output logic [15:0]          frame_count,
   output logic                 err_pulse,
   output logic [7:0]           err_count
);
   localparam int NSLOTS    = NUM_ZONES * SLOTS_PER_ZONE + PAD_SLOTS;
   localparam int MAX_TICKS = (SYNC_TICKS > BIT_TICKS) ? SYNC_TICKS : BIT_TICKS;
   localparam int TW        = $clog2(MAX_TICKS);
   localparam int SW        = $clog2(NSLOTS);

   localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TICKS - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] SAMPLE_AT = TW'(SAMPLE_TICK);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOTS - 1);
   localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

   localparam logic [1:0] ST_SYNC  = 2'd0;
   localparam logic [1:0] ST_DATA  = 2'd1;
   localparam logic [1:0] ST_INTER = 2'd2;

   logic [1:0]           state;
   logic [TW-1:0]        tick;
   logic [SW-1:0]        slot;
   logic [NUM_ZONES-1:0] shed_tx;
   logic [NUM_ZONES-1:0] shed_q;

   logic [NUM_ZONES-1:0] sh_fan_on, sh_fan_high, sh_ac, sh_heat;
   logic [NUM_ZONES-1:0] nx_fan_on, nx_fan_high, nx_ac, nx_heat;
   logic [NUM_ZONES-1:0] st_fan_on, st_fan_high, st_ac, st_heat;

   logic sample_now;
   logic frame_end;
   logic tx_bit;
   logic commit_ok;

   // Slot decode: the tx bit and the shadow image as it stands after this clock's sample.
   // The commit reads nx_* so a sample landing on the very last tick is not lost.
   always_comb begin
      sample_now  = (state == ST_DATA) && (tick == SAMPLE_AT);
      frame_end   = (state == ST_DATA) && (tick == BIT_LAST) && (slot == SLOT_LAST);
      tx_bit      = 1'b0;
      nx_fan_on   = sh_fan_on;
      nx_fan_high = sh_fan_high;
      nx_ac       = sh_ac;
      nx_heat     = sh_heat;
      for (int z = 0; z < NUM_ZONES; z++) begin
         if (int'(slot) == z * SLOTS_PER_ZONE + 2) tx_bit = shed_tx[z];
         if (sample_now) begin
            if (int'(slot) == z * SLOTS_PER_ZONE) begin
               nx_fan_on[z]   = it.tm4;
               nx_fan_high[z] = it.tm2;
            end
            if (int'(slot) == z * SLOTS_PER_ZONE + 1) nx_ac[z]   = it.tm2;
            if (int'(slot) == z * SLOTS_PER_ZONE + 3) nx_heat[z] = it.tm2;
         end
      end
   end

   assign it.mt12 = (state != ST_DATA);
   assign it.mt2  = (state == ST_DATA) & tx_bit;

`ifdef PROTOCOL_CHECK_EN
   assign commit_ok = ~|(nx_fan_on & nx_fan_high);
`else
   assign commit_ok = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_SYNC;
         tick  <= '0;
         slot  <= '0;
      end else begin
         case (state)
            ST_SYNC: begin
               if (tick != SYNC_LAST) begin
                  tick <= tick + TICK_ONE;
               end else if (enable) begin
                  state <= ST_DATA;
                  tick  <= '0;
                  slot  <= '0;
               end
            end
            ST_DATA: begin
               if (tick != BIT_LAST) begin
                  tick <= tick + TICK_ONE;
               end else if (slot == SLOT_LAST) begin
                  state <= ST_SYNC;
                  tick  <= '0;
                  slot  <= '0;
               end else begin
                  state <= ST_INTER;
                  tick  <= '0;
               end
            end
            ST_INTER: begin
               state <= ST_DATA;
               tick  <= '0;
               slot  <= slot + SLOT_ONE;
            end
            default: begin
               state <= ST_SYNC;
               tick  <= '0;
               slot  <= '0;
            end
         endcase
      end
   end

   // Frame-constant shed image is taken on the first SYNC clock; shadows follow the slot samples.
   always_ff @(posedge clock) begin
      shed_q <= shed;
      if (state == ST_SYNC && tick == '0) shed_tx <= shed;
      sh_fan_on   <= nx_fan_on;
      sh_fan_high <= nx_fan_high;
      sh_ac       <= nx_ac;
      sh_heat     <= nx_heat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_fan_on   <= '0;
         st_fan_high <= '0;
         st_ac       <= '0;
         st_heat     <= '0;
         frame_done  <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) frame_count <= frame_count + 16'd1;
         if (frame_end && commit_ok) begin
            st_fan_on   <= nx_fan_on;
            st_fan_high <= nx_fan_high;
            st_ac       <= nx_ac;
            st_heat     <= nx_heat;
         end
      end
   end

`ifdef PROTOCOL_CHECK_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         err_pulse <= 1'b0;
         err_count <= 8'd0;
      end else begin
         err_pulse <= frame_end & ~commit_ok;
         if (frame_end && !commit_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_pulse = 1'b0;
   assign err_count = 8'd0;
`endif

   // Shed overrides committed status through a single register, independent of frame phase.
   assign ac_n       = ~(st_ac & ~shed_q);
   assign fan_on_n   = ~((st_fan_on | st_fan_high) & ~shed_q);
   assign fan_high_n = ~(st_fan_high & ~shed_q);
   assign heat_n     = ~(st_heat & ~shed_q);

endmodule

// File: tb/tb_intellitec_bus_master.sv
// Self-checking bench for intellitec_bus_master: cycle-position frame model with random slave replies and shed.
module tb_intellitec_bus_master;
   localparam int NZ   = 2;
   localparam int SPZ  = 4;
   localparam int PAD  = 2;
   localparam int ST   = 3;
   localparam int BT   = 8;
   localparam int SMP  = 3;
   localparam int NS   = NZ * SPZ + PAD;
   localparam int FLEN = ST + NS * BT + (NS - 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b1;
   logic [NZ-1:0] shed = '0;
   logic [NZ-1:0] ac_n, fan_on_n, fan_high_n, heat_n;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic          err_pulse;
   logic [7:0]    err_count;

   IntellitecSignal it();

   intellitec_bus_master #(
      .NUM_ZONES(NZ), .SLOTS_PER_ZONE(SPZ), .PAD_SLOTS(PAD),
      .SYNC_TICKS(ST), .BIT_TICKS(BT), .SAMPLE_TICK(SMP)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .shed(shed), .it(it),
      .ac_n(ac_n), .fan_on_n(fan_on_n), .fan_high_n(fan_high_n), .heat_n(heat_n),
      .frame_done(frame_done), .frame_count(frame_count),
      .err_pulse(err_pulse), .err_count(err_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [NZ-1:0] m_ac, m_fon, m_fhi, m_heat, m_shed_q;
   int            m_count;
   int            m_err;

   function automatic logic [4*NZ-1:0] exp_relays();
      return {~(m_ac & ~m_shed_q), ~((m_fon | m_fhi) & ~m_shed_q),
              ~(m_fhi & ~m_shed_q), ~(m_heat & ~m_shed_q)};
   endfunction

   // Drives one frame from cycle 0 (SYNC start) and checks every clock against the frame schedule.
   // ev_kind: 0 none, 1 change shed, 2 drop enable, 3 assert reset (frame aborted).
   task automatic run_frame(input logic [NS-1:0] rx2, input logic [NS-1:0] rx4,
                            input int ev_cyc, input int ev_kind, input logic [NZ-1:0] ev_shed,
                            output bit aborted);
      logic [NZ-1:0] tx;
      bit   data;
      bit   legal;
      int   s, d, w;
      logic exp_mt2;
      aborted = 1'b0;
      tx = shed;
      for (int c = 0; c < FLEN; c++) begin
         data = 1'b0;
         s = 0;
         if (c >= ST) begin
            d = c - ST;
            s = d / (BT + 1);
            w = d % (BT + 1);
            data = (w < BT);
         end
         it.tm2 = data ? rx2[s] : 1'b0;
         it.tm4 = data ? rx4[s] : 1'b0;
         exp_mt2 = 1'b0;
         if (data && (s % SPZ == 2) && (s / SPZ < NZ)) exp_mt2 = tx[s / SPZ];
         total++;
         if (it.mt12 !== !data) begin
            bad++;
            $display("FAIL mt12 cycle %0d: got %b expected %b", c, it.mt12, !data);
         end
         total++;
         if (it.mt2 !== exp_mt2) begin
            bad++;
            $display("FAIL mt2 cycle %0d: got %b expected %b", c, it.mt2, exp_mt2);
         end
         total++;
         if ({ac_n, fan_on_n, fan_high_n, heat_n} !== exp_relays()) begin
            bad++;
            $display("FAIL relays cycle %0d: got %b expected %b", c,
                     {ac_n, fan_on_n, fan_high_n, heat_n}, exp_relays());
         end
         if (c > 0) begin
            total++;
            if (frame_done !== 1'b0) begin
               bad++;
               $display("FAIL frame_done_mid cycle %0d: got %b expected 0", c, frame_done);
            end
         end
         if (c == ev_cyc) begin
            case (ev_kind)
               1: shed = ev_shed;
               2: enable = 1'b0;
               3: begin reset = 1'b1; aborted = 1'b1; end
               default: ;
            endcase
         end
         m_shed_q = shed;
         @(negedge clock);
         if (aborted) return;
      end
      legal = 1'b1;
`ifdef PROTOCOL_CHECK_EN
      for (int z = 0; z < NZ; z++) if (rx2[z*SPZ] && rx4[z*SPZ]) legal = 1'b0;
`endif
      if (legal) begin
         for (int z = 0; z < NZ; z++) begin
            m_fon[z]  = rx4[z*SPZ];
            m_fhi[z]  = rx2[z*SPZ];
            m_ac[z]   = rx2[z*SPZ+1];
            m_heat[z] = rx2[z*SPZ+3];
         end
      end else if (m_err < 255) begin
         m_err++;
      end
      m_count = (m_count + 1) & 16'hFFFF;
      total++;
      if (frame_done !== 1'b1) begin
         bad++;
         $display("FAIL frame_done_end: got %b expected 1", frame_done);
      end
      total++;
      if (frame_count !== 16'(m_count)) begin
         bad++;
         $display("FAIL frame_count: got %0d expected %0d", frame_count, m_count);
      end
      total++;
      if ({ac_n, fan_on_n, fan_high_n, heat_n} !== exp_relays()) begin
         bad++;
         $display("FAIL relays_commit: got %b expected %b", {ac_n, fan_on_n, fan_high_n, heat_n}, exp_relays());
      end
      total++;
      if ({err_pulse, err_count} !== {!legal, 8'(m_err)}) begin
         bad++;
         $display("FAIL err: got pulse=%b count=%0d expected pulse=%b count=%0d",
                  err_pulse, err_count, !legal, m_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      shed = '0;
      it.tm2 = 1'b0;
      it.tm4 = 1'b0;
      m_ac = '0; m_fon = '0; m_fhi = '0; m_heat = '0;
      m_count = 0;
      m_err = 0;
      repeat (5) begin
         @(negedge clock);
         total++;
         if ({it.mt12, it.mt2} !== 2'b10) begin
            bad++;
            $display("FAIL reset_bus: got mt12=%b mt2=%b expected 1 0", it.mt12, it.mt2);
         end
         total++;
         if ({ac_n, fan_on_n, fan_high_n, heat_n} !== {4*NZ{1'b1}}) begin
            bad++;
            $display("FAIL reset_relays: got %b expected all ones", {ac_n, fan_on_n, fan_high_n, heat_n});
         end
         total++;
         if ({frame_done, frame_count, err_pulse, err_count} !== 26'd0) begin
            bad++;
            $display("FAIL reset_counters: got done=%b count=%0d errp=%b errc=%0d expected zeros",
                     frame_done, frame_count, err_pulse, err_count);
         end
      end
      m_shed_q = shed;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      bit ab;
      shed = '0;
      run_frame(NS'(10'b00_0000_0010), '0, -1, 0, '0, ab);
      total++;
      if (ac_n[0] !== 1'b0) begin
         bad++;
         $display("FAIL basic_ac0: got %b expected 0", ac_n[0]);
      end
      run_frame('0, '0, -1, 0, '0, ab);
   endtask

   task automatic test_shed();
      bit ab;
      shed = '0;
      run_frame(NS'(10'b00_0010_0000), '0, -1, 0, '0, ab);
      run_frame(NS'(10'b00_0010_0000), '0, 40, 1, NZ'(2'b10), ab);
      total++;
      if (ac_n[1] !== 1'b1) begin
         bad++;
         $display("FAIL shed_ac1: got %b expected 1", ac_n[1]);
      end
      run_frame(NS'(10'b00_0010_0000), '0, -1, 0, '0, ab);
      shed = '0;
      run_frame($urandom, $urandom, -1, 0, '0, ab);
   endtask

   task automatic test_back_to_back();
      bit ab;
      for (int i = 0; i < 10; i++) begin
         shed = NZ'($urandom);
         run_frame(NS'($urandom), NS'($urandom), $urandom_range(FLEN - 1, 1), 1, NZ'($urandom), ab);
      end
   endtask

   task automatic test_illegal_fan();
      bit ab;
      shed = '0;
      run_frame(NS'(10'b00_0000_0001), NS'(10'b00_0000_0001), -1, 0, '0, ab);
`ifndef PROTOCOL_CHECK_EN
      total++;
      if ({fan_high_n[0], fan_on_n[0]} !== 2'b00) begin
         bad++;
         $display("FAIL illegal_fan: got high_n=%b on_n=%b expected 0 0", fan_high_n[0], fan_on_n[0]);
      end
`endif
   endtask

   task automatic test_enable();
      bit ab;
      shed = '0;
      run_frame(NS'($urandom), NS'($urandom), 3 + 3 * (BT + 1), 2, '0, ab);
      repeat (20) begin
         @(negedge clock);
         total++;
         if ({it.mt12, it.mt2, frame_done} !== 3'b100) begin
            bad++;
            $display("FAIL enable_hold: got mt12=%b mt2=%b done=%b expected 1 0 0", it.mt12, it.mt2, frame_done);
         end
         total++;
         if (frame_count !== 16'(m_count) ||
             {ac_n, fan_on_n, fan_high_n, heat_n} !== exp_relays()) begin
            bad++;
            $display("FAIL enable_stable: got count=%0d relays=%b expected count=%0d relays=%b",
                     frame_count, {ac_n, fan_on_n, fan_high_n, heat_n}, m_count, exp_relays());
         end
      end
      test_reset();
   endtask

   task automatic test_reset_abort();
      bit ab;
      shed = '0;
      run_frame(NS'(10'b00_1010_1010), NS'(10'b00_0001_0001), -1, 0, '0, ab);
      run_frame(NS'($urandom), NS'($urandom), 3 + 5 * (BT + 1) + 4, 3, '0, ab);
      total++;
      if (ab !== 1'b1) begin
         bad++;
         $display("FAIL abort_taken: got %b expected 1", ab);
      end
      m_ac = '0; m_fon = '0; m_fhi = '0; m_heat = '0;
      m_count = 0;
      m_err = 0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({frame_done, frame_count, it.mt12} !== {1'b0, 16'd0, 1'b1} ||
             {ac_n, fan_on_n, fan_high_n, heat_n} !== {4*NZ{1'b1}}) begin
            bad++;
            $display("FAIL abort_state: got done=%b count=%0d mt12=%b relays=%b expected 0 0 1 all ones",
                     frame_done, frame_count, it.mt12, {ac_n, fan_on_n, fan_high_n, heat_n});
         end
         if (i < 2) @(negedge clock);
      end
      reset = 1'b0;
      run_frame(NS'(10'b00_0010_0010), '0, -1, 0, '0, ab);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shed();
      test_back_to_back();
      test_illegal_fan();
      test_enable();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
